// File: rtl/led_count_bank.sv
// led_count_bank: multi-channel up/down counter bank on a single clock.
// A prescaler produces a one-cycle clock-enable tick. The counters step on that tick.
// One selected channel drives the LED bank as binary, one-hot or bar-graph.
module led_count_bank #(
  parameter int  CLK_DIV        = 100000000,
  parameter int  WIDTH          = 4,
  parameter int  CHANNELS       = 2,
  parameter int  LED_N          = 16,
  parameter int  LED_ACTIVE_LOW = 1,
  localparam int SEL_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      direction,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       chan_en,
  input  logic                      sat_en,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_val,
  output logic [CHANNELS*WIDTH-1:0] count_bus,
  output logic [LED_N-1:0]          led,
  output logic                      tick,
  output logic [CHANNELS-1:0]       wrap
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  // Scratch width for the LED decode: wide enough for the count, the LED index and a 32-bit loop index.
  localparam int XW0 = (WIDTH > LED_N) ? WIDTH : LED_N;
  localparam int XW  = (XW0 > 32) ? XW0 : 32;
  localparam logic [LED_N-1:0] LED_OFF = (LED_ACTIVE_LOW != 0) ? {LED_N{1'b1}} : {LED_N{1'b0}};

  logic rst_n;
  assign rst_n = reset;

  logic [PW-1:0]                presc_q, presc_d;
  logic                         dir_meta_q, dir_meta_d;
  logic                         dir_s_q, dir_s_d;
  logic [CHANNELS-1:0][WIDTH-1:0] count_q, count_d;
  logic [CHANNELS-1:0]          wrap_q, wrap_d;
  logic [LED_N-1:0]             led_q, led_d;

  logic [WIDTH-1:0] c_sel;
  logic [XW-1:0]    c_ext;
  logic [XW-1:0]    c_mod;
  logic [LED_N-1:0] pat;

  // The prescaler wraps at CLK_DIV-1. It freezes while enable is low.
  always_comb begin
    presc_d = presc_q;
    if (enable) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    end
  end

  // tick comes straight from the registered prescaler, so it is never high while reset holds presc_q at 0.
  assign tick = enable && (presc_q == PRESC_MAX);

  // The direction switch goes through a two-flop synchroniser before the counters use it.
  always_comb begin
    dir_meta_d = direction;
    dir_s_d    = dir_meta_q;
  end

  // Per-channel next count. A load beats a tick. Each step either saturates or wraps at the limits.
  always_comb begin
    count_d = count_q;
    wrap_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (load && (sel == SEL_W'(i))) begin
        count_d[i] = load_val;
      end else if (tick && chan_en[i]) begin
        if (dir_s_q) begin
          if (count_q[i] == CNT_MAX) begin
            if (!sat_en) begin
              count_d[i] = '0;
              wrap_d[i]  = 1'b1;
            end
          end else begin
            count_d[i] = count_q[i] + WIDTH'(1);
          end
        end else begin
          if (count_q[i] == '0) begin
            if (!sat_en) begin
              count_d[i] = CNT_MAX;
              wrap_d[i]  = 1'b1;
            end
          end else begin
            count_d[i] = count_q[i] - WIDTH'(1);
          end
        end
      end
    end
  end

  // Select the channel shown on the LEDs. An out-of-range sel falls back to channel 0.
  always_comb begin
    c_sel = count_q[0];
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i)) c_sel = count_q[i];
    end
  end

  // Decode the LED pattern from the selected count, then apply pin polarity last.
  always_comb begin
    c_ext = XW'(c_sel);
    c_mod = c_ext % XW'(LED_N);
    pat   = '0;
    case (mode)
      2'b00: pat = c_ext[LED_N-1:0];
      2'b01: for (int k = 0; k < LED_N; k++) pat[k] = (c_mod == XW'(k));
      2'b10: for (int k = 0; k < LED_N; k++) pat[k] = (XW'(k) < c_ext);
      default: pat = '0;
    endcase
    led_d = (LED_ACTIVE_LOW != 0) ? ~pat : pat;
  end

  // All state registers share one async active-low reset. led resets to the inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      dir_meta_q <= 1'b0;
      dir_s_q    <= 1'b0;
      count_q    <= '0;
      wrap_q     <= '0;
      led_q      <= LED_OFF;
    end else begin
      presc_q    <= presc_d;
      dir_meta_q <= dir_meta_d;
      dir_s_q    <= dir_s_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      led_q      <= led_d;
    end
  end

  assign count_bus = count_q;
  assign wrap      = wrap_q;
  assign led       = led_q;

endmodule
